nibble_serial_addsub: RTL and testbench
=======================================

// Module: nibble_serial_addsub
// PURPOSE
//  Multi-word add/subtract engine: accepts WIDTH-bit operand pairs over a valid/ready handshake,
//  processes one 4-bit nibble per cycle through a registered-carry 4-bit add/sub slice (LSB first),
//  returns the WIDTH-bit result with carry/borrow and signed-overflow flags over a second handshake.
//  Sits between the operand source and the 4-bit add/sub datapath: it sequences nibbles into the slice
//  and assembles the slice outputs into the final result.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; multiple of 4, >= 8. NIB = WIDTH/4 (derived, not overridable)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand request valid
//  in_ready    out  1      engine can accept a request (high only in IDLE)
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_sub      in   1      0: A+B, 1: A-B (A + ~B + 1)
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_result  out  WIDTH  sum/difference (saturated when ADDSUB_SAT_EN and overflow)
//  out_cb      out  1      carry out of MSB; for subtract, 1 = no borrow, 0 = borrow
//  out_ovf     out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, nibble index=0, carry=0; out_valid=0, out_result=0,
//    out_cb=0, out_ovf=0; in_ready=1 (IDLE).
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid: capture in_a, in_b, in_sub; carry<=in_sub; idx<=0; -> RUN.
//    RUN: each cycle slice computes a[idx] + (b[idx]^{4{sub}}) + carry; result nibble idx written,
//         carry<=slice cout, idx<=idx+1. When idx==NIB-1: out_cb<=cout, out_ovf computed, -> DONE.
//    DONE: out_valid=1, outputs stable; on out_ready -> IDLE (out_valid drops next cycle).
//  - in_ready=0 in RUN and DONE; requests are not accepted while busy or holding a result.
//  - Latency: out_valid rises NIB+1 cycles after the accepting edge (5 cycles at WIDTH=16).
//    Throughput: one op per NIB+2 cycles with out_ready held high.
//  - Overflow: ovf = (a_msb == bmod_msb) && (sum_msb != a_msb), bmod = b ^ {WIDTH{sub}}.
//  - Operand inputs are ignored outside the IDLE accept cycle; changing them mid-op has no effect.
//  - out_result/out_cb/out_ovf hold their last value after DONE until the next op completes.
//  - rst_n low mid-RUN or mid-DONE: op aborted, no result delivered, all outputs to reset values.
//  - Widths: no truncation beyond WIDTH; carry beyond MSB reported only via out_cb.
// CONFIGURATION
//  ADDSUB_SAT_EN defined: on out_ovf=1, out_result saturates to 0x7F..F if a_msb=0, 0x80..0 if a_msb=1;
//    saturation applied in the RUN->DONE transition, no added latency; out_cb/out_ovf unchanged.
//  ADDSUB_SAT_EN undefined: out_result is the raw wrapped WIDTH-bit result; no saturation logic.
// STRUCTURE
//  - Package addsub_pkg: state enum {IDLE, RUN, DONE}, NIBBLE_W=4 constant, saturation-value function.
//  - Sub-module addsub_nibble: combinational 4-bit slice (a, b, sub, cin -> sum, cout) with explicit
//    carry-in; one instance, time-multiplexed over nibbles by this block.
// TESTING (WIDTH=16)
//  - 0x1234 + 0x0FFF -> out_result=0x2233, out_cb=0, out_ovf=0, out_valid 5 cycles after accept.
//  - 0x0005 - 0x0007 -> out_result=0xFFFE, out_cb=0 (borrow), out_ovf=0.
//  - 0x7FFF + 0x0001 -> ovf=1, cb=0; result 0x8000 (SAT off) / 0x7FFF (SAT on).
//  - 0x8000 - 0x0001 -> ovf=1, cb=1; result 0x7FFF (SAT off) / 0x8000 (SAT on).
//  - Backpressure: out_ready low 5 cycles in DONE -> out_valid and outputs held, in_ready=0, new in_valid
//    ignored; out_ready high -> IDLE next cycle, in_ready=1.
//  - Reset mid-RUN (rst_n low on 2nd RUN cycle) -> outputs 0, out_valid never asserted; after release
//    0x0001 + 0x0001 completes with out_result=0x0002.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
// Holds the control state encoding, the slice width and the saturation-value helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W  = 4;
  // Widest result the saturation helper can describe.
  localparam int SAT_MAX_W = 64;

  // Most-positive (a_msb=0) or most-negative (a_msb=1) two's-complement value of the given width.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic a_msb, input int width);
    logic [SAT_MAX_W-1:0] msb_only;
    msb_only = SAT_MAX_W'(1) << (width - 1);
    return a_msb ? msb_only : (msb_only - SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit add/subtract slice with explicit carry-in.
// Subtraction inverts b here; the +1 arrives through cin from the sequencer.
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_mod;

  assign b_mod       = b ^ {NIBBLE_W{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_mod} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract engine: one nibble per cycle through a registered-carry slice, LSB first.
// Optional feature: define ADDSUB_SAT_EN to saturate the result on signed overflow.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cb,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t state_q, state_d;

  // Operands shift right one nibble per RUN cycle, so the slice always sees bits [3:0].
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             sub_q, carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                accept, last_nib, ovf_d;
  logic [WIDTH-1:0]    final_raw, result_d;

  addsub_nibble u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_nib  = (state_q == RUN) && (idx_q == LAST_IDX);
  // Result builds from the top down: each new nibble enters at the MSB end.
  assign final_raw = {slice_sum, res_q[WIDTH-1:NIBBLE_W]};

  // On the last nibble a_q/b_q hold the operand MSB nibble, so bit 3 is the sign bit.
  assign ovf_d = (a_q[NIBBLE_W-1] == (b_q[NIBBLE_W-1] ^ sub_q)) &&
                 (slice_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);

`ifdef ADDSUB_SAT_EN
  assign result_d = ovf_d ? WIDTH'(sat_value(a_q[NIBBLE_W-1], WIDTH)) : final_raw;
`else
  assign result_d = final_raw;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      sub_q   <= in_sub;
      carry_q <= in_sub;
      idx_q   <= '0;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
      b_q     <= {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
      carry_q <= slice_cout;
      idx_q   <= idx_q + IDX_W'(1);
      res_q   <= final_raw;
    end
  end

  // Delivered outputs change only when an operation completes and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_cb     <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (last_nib) begin
      out_result <= result_d;
      out_cb     <= slice_cout;
      out_ovf    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub at WIDTH=16: directed table, corner sequences and
// random operations against a plain-arithmetic reference model. Honours ADDSUB_SAT_EN if defined.
module tb_nibble_serial_addsub;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_cb, out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cb     (out_cb),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cb;
    logic         ovf;
  } result_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cb;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, overflow as "true signed result out of range".
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    result_t r;
    int unsigned ua, ub, ur;
    int sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua + (32'd1 << W) - ub;
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      sr = sa + sb;
    end
    r.res = ur[W-1:0];
    r.cb  = ur[W];
    r.ovf = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
    if (SAT_ON && r.ovf) r.res = a[W-1] ? W'(1 << (W - 1)) : W'((1 << (W - 1)) - 1);
    return r;
  endfunction

  // Accept cycle counts as cycle 1; lat is the cycle in which out_valid is first seen high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output result_t r, output int lat, output bit got);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    got   = out_valid;
    r.res = out_result;
    r.cb  = out_cb;
    r.ovf = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t    vecs[7];
  result_t r, m;
  int      lat;
  bit      got;
  int      seen_valid;

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, SAT_ON ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, SAT_ON ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, SAT_ON ? 16'h8000 : 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", 32'(out_result), 32'd0);
    check("reset flags", {30'd0, out_cb, out_ovf}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, lat, got);
      check($sformatf("vec%0d valid", i), 32'(got), 32'd1);
      check($sformatf("vec%0d result", i), 32'(r.res), 32'(vecs[i].res));
      check($sformatf("vec%0d cb", i), 32'(r.cb), 32'(vecs[i].cb));
      check($sformatf("vec%0d ovf", i), 32'(r.ovf), 32'(vecs[i].ovf));
      if (i == 0) check("latency", 32'(lat), 32'(NIB + 1));
      check($sformatf("vec%0d idle after", i), {30'd0, in_ready, out_valid}, 32'd2);
    end

    // Backpressure: result held in DONE while competing requests are presented.
    in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b1;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp result", 32'(out_result), 32'h3333);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    check("bp hold after done", 32'(out_result), 32'h3333);
    check("bp no new op", 32'(in_ready), 32'd1);

    // Reset on the second RUN cycle aborts the operation.
    in_a = 16'h7FFF; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort result", 32'(out_result), 32'd0);
    check("abort flags", {29'd0, out_valid, out_cb, out_ovf}, 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    check("abort no result", 32'(seen_valid), 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, r, lat, got);
    check("post-reset valid", 32'(got), 32'd1);
    check("post-reset result", 32'(r.res), 32'h0002);

    // Random operations, biased toward sign-boundary operands.
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
      m = model(a, b, s);
      do_op(a, b, s, r, lat, got);
      check($sformatf("rnd%0d valid", i), 32'(got), 32'd1);
      check($sformatf("rnd%0d %h%s%h result", i, a, s ? "-" : "+", b), 32'(r.res), 32'(m.res));
      check($sformatf("rnd%0d flags", i), {30'd0, r.cb, r.ovf}, {30'd0, m.cb, m.ovf});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
